// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and overflow / underflow error pulses.
//
// Parameters:
//   WIDTH    data word width in bits (>= 1)
//   DEPTH    number of entries, power of 2, >= 4
//   AF_LEVEL almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous reset, active-high
//   wr / din      write request and write data
//   rd            read request (pop/acknowledge in FWFT mode)
//   dout          read data
//   empty, full, almost_empty, almost_full   status flags from count
//   count         current occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
//
// Build option:
//   SYNC_FIFO_FWFT_EN  when defined, dout shows the head entry continuously
//                      (first-word-fall-through) and rd pops it; otherwise
//                      dout is registered and updates the cycle after an
//                      accepted read.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept;
    logic          rd_accept;

    // Flags decode the registered count only, so they cannot glitch when
    // wr and rd arrive together.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path (defaults
        // first), otherwise synthesis infers a latch to hold the old value.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // A write into a full FIFO is still accepted when a read frees a slot
        // on the same edge; a read from an empty FIFO never is.
        wr_accept   = wr && (!full || rd);
        rd_accept   = rd && !empty;

        if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = wr && full && !rd;
        underflow_d = rd && empty;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always visible; contents are meaningless while empty.
    assign dout = mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    // Output register loads only on an accepted read and holds otherwise,
    // including across a rejected read.
    always_comb begin
        dout_d = dout_q;
        if (rd_accept) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16,
// AF_LEVEL=12, AE_LEVEL=2). Inputs change and outputs are sampled 1 ns after
// each rising clock edge. Build with SYNC_FIFO_FWFT_EN defined to exercise the
// first-word-fall-through sequence instead of the registered-output sequence.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_param #(
        .WIDTH    (8),
        .DEPTH    (16),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected flags come from the expected occupancy and the fixed thresholds.
    task automatic check_level(input string tag, input int exp_count);
        check({tag, ".count"},        int'(count),        exp_count);
        check({tag, ".empty"},        int'(empty),        int'(exp_count == 0));
        check({tag, ".full"},         int'(full),         int'(exp_count == 16));
        check({tag, ".almost_empty"}, int'(almost_empty), int'(exp_count <= 2));
        check({tag, ".almost_full"},  int'(almost_full),  int'(exp_count >= 12));
    endtask

    // One clock: drive inputs, take the rising edge, settle 1 ns.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_level("reset", 0);
        check("reset.overflow",  int'(overflow),  0);
        check("reset.underflow", int'(underflow), 0);

`ifdef SYNC_FIFO_FWFT_EN
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        check_level("fwft.two", 2);
        check("fwft.head", int'(dout), 'h11);
        cycle(1'b0, 1'b0, 8'h00);
        check("fwft.head_hold", int'(dout), 'h11);
        cycle(1'b0, 1'b1, 8'h00);
        check("fwft.pop1", int'(dout), 'h22);
        check_level("fwft.pop1", 1);
        cycle(1'b0, 1'b1, 8'h00);
        check_level("fwft.pop2", 0);
        cycle(1'b0, 1'b1, 8'h00);
        check("fwft.underflow", int'(underflow), 1);
        check_level("fwft.underflow", 0);
`else
        // Fill 0x01..0x10, watching count and every flag step.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            check_level($sformatf("fill%0d", i), i);
            check($sformatf("fill%0d.overflow", i), int'(overflow), 0);
        end
        // Write while full: rejected, one-cycle overflow pulse.
        cycle(1'b1, 1'b0, 8'h99);
        check("ovf.pulse", int'(overflow), 1);
        check_level("ovf", 16);
        cycle(1'b0, 1'b0, 8'h00);
        check("ovf.clear", int'(overflow), 0);

        // Drain: 0x01..0x10 in order, one cycle after each rd.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d.dout", i), int'(dout), i);
            check_level($sformatf("drain%0d", i), 16 - i);
        end
        // Read while empty: rejected, underflow pulse, dout holds.
        cycle(1'b0, 1'b1, 8'h00);
        check("unf.pulse", int'(underflow), 1);
        check("unf.dout_hold", int'(dout), 'h10);
        check_level("unf", 0);
        cycle(1'b0, 1'b0, 8'h00);
        check("unf.clear", int'(underflow), 0);
        check("unf.dout_hold2", int'(dout), 'h10);

        // Wrap-around: move pointers to 10, then fill 16 across the wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("pre%0d.dout", i), int'(dout), 'h20 + i);
        end
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        check_level("wrap.full", 16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap%0d.dout", i), int'(dout), 'hA0 + i);
        end
        check_level("wrap.empty", 0);

        // Full with wr=rd=1: both accepted, no overflow, 0x55 goes to the tail.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hB0 + i));
        cycle(1'b1, 1'b1, 8'h55);
        check_level("fullrw", 16);
        check("fullrw.overflow", int'(overflow), 0);
        check("fullrw.dout", int'(dout), 'hB0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check($sformatf("fullrw%0d.dout", i), int'(dout),
                  (i == 16) ? 'h55 : 'hB0 + i);
        end
        check_level("fullrw.drained", 0);

        // Empty with wr=rd=1: only the write lands, underflow pulses.
        cycle(1'b1, 1'b1, 8'h66);
        check_level("emptyrw", 1);
        check("emptyrw.underflow", int'(underflow), 1);
        check("emptyrw.dout_hold", int'(dout), 'h55);
        cycle(1'b0, 1'b1, 8'h00);
        check("emptyrw.read", int'(dout), 'h66);
        check("emptyrw.unf_clear", int'(underflow), 0);
        check_level("emptyrw.drained", 0);

        // Async reset between edges with 7 entries held.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h70 + i));
        check_level("prerst", 7);
        #2;
        rst = 1'b1;
        #1;
        check_level("arst", 0);
        check("arst.dout", int'(dout), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_level("arst.release", 0);
        cycle(1'b1, 1'b0, 8'h33);
        check_level("arst.write", 1);
        cycle(1'b0, 1'b1, 8'h00);
        check("arst.read", int'(dout), 'h33);
        check_level("arst.final", 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
